cal_out_scaler: RTL and testbench
=================================

Name: cal_out_scaler

Overview:
- Output calibration stage that sits directly downstream of any 4-channel audio core.
- Takes the core's four signed samples once per sample frame and applies per-channel gain (signed fixed-point) and offset, with saturation.
- Presents calibrated samples to the codec output path.
- Uses one time-multiplexed multiplier, sequenced by a small state machine; coefficients are loaded at runtime through a register write port.

Parameters:
- W, 16, sample width (signed) for inputs and outputs.
- GAIN_W, 16, signed gain coefficient width.
- GAIN_FRAC, 14, fractional bits of gain; unity = 1<<GAIN_FRAC = 16384.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sample_clk  in  1  frame strobe level, synchronous to clk; each rising edge starts one frame.
- sample_in0..sample_in3  in  W (signed)  core output samples.
- jack  in  8  patch detect; bits [7:4] = output jacks 0..3.
- cal_we  in  1  coefficient write enable, one cycle.
- cal_sel  in  3  {is_offset, ch[1:0]}.
- cal_wdata  in  16 (signed)  gain (Q2.14) or offset (sample LSBs).
- sample_out0..sample_out3  out  W (signed)  calibrated samples.
- out_valid  out  1  one-cycle pulse when sample_out* update.
- busy  out  1  high from capture through commit.
- overrun  out  1  sticky; set when a frame edge arrives while busy.

Behaviour:
- Reset (rst=0, async):
  - sample_out* = 0; out_valid = 0; busy = 0; overrun = 0; state = IDLE.
  - Active and shadow gains = 16384; offsets = 0; sample_clk_d = 0.
- Edge detect: start = sample_clk & ~sample_clk_d, with sample_clk_d registered every cycle.
- States: IDLE, MUL, ADD, COMMIT.
- IDLE, on start at clock edge E0:
  - snapshot sample_in0..3;
  - copy shadow coefficients to active;
  - ch = 0; state -> MUL.
- MUL: prod <= snap[ch] * gain[ch] (signed, W+GAIN_W bits); state -> ADD.
- ADD:
  - sum = (prod >>> GAIN_FRAC) + sign-extended offset[ch];
  - arithmetic shift truncates toward -inf;
  - res[ch] <= sum saturated to [-2^(W-1), 2^(W-1)-1];
  - if ch == 3, state -> COMMIT; else ch++, state -> MUL.
- COMMIT, at E9: sample_out* <= res*; out_valid = 1 for this cycle only; state -> IDLE.
- Latency: outputs and out_valid are registered at E9, i.e. 9 clocks after the snapshot edge.
- Minimum frame period: 10 clk.
- busy is high from after E0 through COMMIT, inclusive.
- sample_in* may change freely after E0.
- start while state != IDLE: ignored; overrun set, cleared only by reset.
- start in the same cycle as COMMIT: ignored; overrun set.
- Coefficient writes:
  - cal_we writes the shadow register selected by cal_sel, in any state.
  - Writes take effect at the next capture; the frame in progress never mixes old and new coefficients.
- Write coinciding with capture at E0: the copy uses pre-write shadow values; the write lands in shadow and applies to the following frame.
- Outputs hold their values between commits.
- Reset asserted mid-frame: the frame is abandoned and all outputs return to reset values immediately.

Optional Feature:
- Macro: CAL_MUTE_UNPATCHED_EN.
- Defined: at COMMIT, sample_outN is forced to 0 when jack[4+N] == 0 at that cycle. out_valid and the computation are unchanged.
- Undefined: jack is ignored and outputs are always the calibrated result.

Decomposition:
- Package cal_pkg:
  - state enum cal_state_t {IDLE, MUL, ADD, COMMIT};
  - GAIN_UNITY localparam;
  - cal_sel field positions;
  - channel index type ch_t (2-bit).
- One sub-module, sat_clamp (parameterized input width and output width W): pure saturating narrowing, reused by other cores.

Test Plan:
- Unity coefficients from reset; in0=4000, in3=-4000, edge at E0 -> out0=4000, out3=-4000; out_valid pulses exactly at E9; busy high E1..E9.
- Write gain ch1 = 8192; in1=-4000 -> out1=-2000. Gain ch2 = 8192; in2=-1 -> out2=-1 (floor).
- Offset ch0 = 1000; in0=32000 -> out0=32767. Gain ch3 = -16384; in3=-32768 -> out3=32767. Offset ch1 = -1000; in1=-32000 -> out1=-32768.
- Second sample_clk rising edge at E4 -> no restart, results unchanged, overrun=1 and stays 1; next edge after E9 processes normally.
- Write gain ch0 = 8192 during a busy frame with in0=4000 -> that frame's out0=4000; next frame out0=2000.
- rst low at E5 -> all outputs 0 and state IDLE immediately; after release, first edge yields correct results.
- With CAL_MUTE_UNPATCHED_EN and jack=8'h30 -> out0/out1 calibrated, out2/out3 = 0. Without the macro -> all four calibrated.

Source files
------------

// File: rtl/cal_pkg.sv
// cal_pkg: shared types and constants for the output calibration stage
//   cal_state_t : sequencer states
//   ch_t        : channel index
//   GAIN_UNITY  : Q2.14 unity gain
//   SEL_OFS_BIT : cal_sel bit choosing offset (1) vs gain (0)
package cal_pkg;
    typedef enum logic [1:0] {IDLE, MUL, ADD, COMMIT} cal_state_t;
    typedef logic [1:0] ch_t;
    localparam int CAL_DW = 16;
    localparam logic signed [CAL_DW-1:0] GAIN_UNITY = 16'sd16384;
    localparam int SEL_OFS_BIT = 2;
    localparam int SEL_CH_MSB = 1;
endpackage

// File: rtl/sat_clamp.sv
// sat_clamp: saturating narrowing of a signed value
//   in_i  [IN_W]  signed wide value
//   out_o [OUT_W] signed value clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
module sat_clamp #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o
);
    logic [IN_W-OUT_W:0] hi;
    logic ovf;
    // fits only when every dropped bit equals the new sign bit
    assign hi = in_i[IN_W-1:OUT_W-1];
    assign ovf = ~((&hi) | ~(|hi));
    assign out_o = ovf ? (in_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}})
                       : in_i[OUT_W-1:0];
endmodule

// File: rtl/cal_out_scaler.sv
// cal_out_scaler: per-channel gain/offset calibration of four samples using one shared multiplier
//   clk, rst (async active-low), sample_clk (frame strobe level)
//   sample_in0..3 : core samples, captured on the sample_clk rising edge
//   jack[7:4]     : patch detect, used only when CAL_MUTE_UNPATCHED_EN is defined
//   cal_we/cal_sel/cal_wdata : shadow coefficient write port, cal_sel = {is_offset, ch}
//   sample_out0..3, out_valid : calibrated samples and their one-cycle update pulse
//   busy, overrun : frame in progress, sticky lost-frame flag
// Optional: CAL_MUTE_UNPATCHED_EN zeroes each output whose jack bit is low at commit.
module cal_out_scaler
    import cal_pkg::*;
#(
    parameter int W         = 16,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic signed [W-1:0] sample_in0,
    input  logic signed [W-1:0] sample_in1,
    input  logic signed [W-1:0] sample_in2,
    input  logic signed [W-1:0] sample_in3,
    input  logic [7:0]          jack,
    input  logic                cal_we,
    input  logic [2:0]          cal_sel,
    input  logic signed [15:0]  cal_wdata,
    output logic signed [W-1:0] sample_out0,
    output logic signed [W-1:0] sample_out1,
    output logic signed [W-1:0] sample_out2,
    output logic signed [W-1:0] sample_out3,
    output logic                out_valid,
    output logic                busy,
    output logic                overrun
);
    localparam int PW = W + GAIN_W;
    localparam int SW = PW + 1;
    cal_state_t state_q;
    ch_t ch_q;
    logic sample_clk_q, out_valid_q, busy_q, overrun_q;
    logic signed [W-1:0] snap_q [4];
    logic signed [W-1:0] res_q [4];
    logic signed [W-1:0] out_q [4];
    logic signed [GAIN_W-1:0] gain_act_q [4];
    logic signed [GAIN_W-1:0] gain_sh_q [4];
    logic signed [CAL_DW-1:0] off_act_q [4];
    logic signed [CAL_DW-1:0] off_sh_q [4];
    logic signed [PW-1:0] prod_q, prod_sh;
    logic signed [SW-1:0] sum;
    logic signed [W-1:0] sat;
    logic start, unused_jack;
    assign start = sample_clk & ~sample_clk_q;
    // arithmetic shift floors toward -inf
    assign prod_sh = prod_q >>> GAIN_FRAC;
    assign sum = SW'(prod_sh) + SW'(off_act_q[ch_q]);
    assign unused_jack = ^jack;
    sat_clamp #(.IN_W(SW), .OUT_W(W)) u_sat (.in_i(sum), .out_o(sat));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ch_q <= '0;
            sample_clk_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q <= 1'b0;
            overrun_q <= 1'b0;
            prod_q <= '0;
            for (int i = 0; i < 4; i++) begin
                snap_q[i] <= '0;
                res_q[i] <= '0;
                out_q[i] <= '0;
                gain_act_q[i] <= GAIN_W'(GAIN_UNITY);
                gain_sh_q[i] <= GAIN_W'(GAIN_UNITY);
                off_act_q[i] <= '0;
                off_sh_q[i] <= '0;
            end
        end else begin
            sample_clk_q <= sample_clk;
            out_valid_q <= 1'b0;
            if (cal_we && cal_sel[SEL_OFS_BIT]) off_sh_q[cal_sel[SEL_CH_MSB:0]] <= cal_wdata;
            if (cal_we && !cal_sel[SEL_OFS_BIT]) gain_sh_q[cal_sel[SEL_CH_MSB:0]] <= GAIN_W'(cal_wdata);
            if (start && state_q != IDLE) overrun_q <= 1'b1;
            case (state_q)
                IDLE: if (start) begin
                    // active copy reads pre-write shadow values, so a coincident write waits a frame
                    snap_q <= '{sample_in0, sample_in1, sample_in2, sample_in3};
                    gain_act_q <= gain_sh_q;
                    off_act_q <= off_sh_q;
                    ch_q <= '0;
                    busy_q <= 1'b1;
                    state_q <= MUL;
                end
                MUL: begin
                    prod_q <= PW'(snap_q[ch_q]) * PW'(gain_act_q[ch_q]);
                    state_q <= ADD;
                end
                ADD: begin
                    res_q[ch_q] <= sat;
                    ch_q <= ch_q + 2'd1;
                    state_q <= (ch_q == 2'd3) ? COMMIT : MUL;
                end
                COMMIT: begin
                    for (int i = 0; i < 4; i++)
`ifdef CAL_MUTE_UNPATCHED_EN
                        out_q[i] <= jack[4+i] ? res_q[i] : '0;
`else
                        out_q[i] <= res_q[i];
`endif
                    out_valid_q <= 1'b1;
                    busy_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign sample_out0 = out_q[0];
    assign sample_out1 = out_q[1];
    assign sample_out2 = out_q[2];
    assign sample_out3 = out_q[3];
    assign out_valid = out_valid_q;
    assign busy = busy_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_cal_out_scaler.sv
// tb_cal_out_scaler: directed vector bench for cal_out_scaler
module tb_cal_out_scaler;
    typedef logic signed [15:0] s16_t;
    typedef s16_t s4_t [4];
    typedef struct {
        s4_t in;
        s4_t g;
        s4_t o;
        s4_t e;
    } vec_t;
    localparam s16_t U = 16'sd16384;
    localparam s16_t Z = 16'sd0;
    logic clk = 1'b0, rst = 1'b0, sample_clk = 1'b0, cal_we = 1'b0;
    logic [7:0] jack = 8'hF0;
    logic [2:0] cal_sel = 3'd0;
    s16_t cal_wdata = 16'sd0;
    s16_t si [4];
    s16_t so [4];
    logic out_valid, busy, overrun;
    int n_vec = 0, n_bad = 0;
    vec_t tv [4];
    s4_t ones, zeros, e_mute;

    cal_out_scaler dut (
        .clk(clk), .rst(rst), .sample_clk(sample_clk),
        .sample_in0(si[0]), .sample_in1(si[1]), .sample_in2(si[2]), .sample_in3(si[3]),
        .jack(jack), .cal_we(cal_we), .cal_sel(cal_sel), .cal_wdata(cal_wdata),
        .sample_out0(so[0]), .sample_out1(so[1]), .sample_out2(so[2]), .sample_out3(so[3]),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] sel, input s16_t d);
        @(negedge clk);
        cal_we = 1'b1;
        cal_sel = sel;
        cal_wdata = d;
        @(negedge clk);
        cal_we = 1'b0;
    endtask

    task automatic load(input s4_t g, input s4_t o);
        for (int c = 0; c < 4; c++) begin
            wr({1'b0, 2'(c)}, g[c]);
            wr({1'b1, 2'(c)}, o[c]);
        end
    endtask

    // reedge / wr_k: clock edge (relative to capture E0) of an extra frame edge / a coefficient write
    task automatic run_frame(input string nm, input s4_t iv, input s4_t ev, input int reedge,
                             input int wr_k, input logic [2:0] ws, input s16_t wd);
        int lat, vc;
        logic b1, b8, b9;
        lat = 0;
        vc = 0;
        b8 = 1'b0;
        b9 = 1'b1;
        @(negedge clk);
        si = iv;
        sample_clk = 1'b1;
        cal_sel = ws;
        cal_wdata = wd;
        cal_we = (wr_k == 0);
        @(posedge clk);
        #1 b1 = busy;
        @(negedge clk);
        sample_clk = (reedge == 1);
        cal_we = (wr_k == 1);
        si = '{16'sh7777, -16'sd1234, 16'sd999, -16'sd32768};
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                vc++;
                lat = k;
            end
            if (k == 8) b8 = busy;
            if (k == 9) b9 = busy;
            if (k < 9) begin
                @(negedge clk);
                sample_clk = (reedge == k + 1);
                cal_we = (wr_k == k + 1);
            end
        end
        if (sample_clk || cal_we) begin
            @(negedge clk);
            sample_clk = 1'b0;
            cal_we = 1'b0;
        end
        for (int n = 0; n < 4; n++) chk($sformatf("%s out%0d", nm, n), int'(so[n]), int'(ev[n]));
        chk({nm, " valid_latency"}, lat, 9);
        chk({nm, " valid_pulses"}, vc, 1);
        chk({nm, " busy_E1_E8_E9"}, int'({b1, b8, b9}), 6);
    endtask

    initial begin
        ones = '{U, U, U, U};
        zeros = '{Z, Z, Z, Z};
        tv[0] = '{'{16'sd4000, Z, Z, -16'sd4000}, ones, zeros, '{16'sd4000, Z, Z, -16'sd4000}};
        tv[1] = '{'{Z, -16'sd4000, -16'sd1, Z}, '{U, 16'sd8192, 16'sd8192, U}, zeros,
                  '{Z, -16'sd2000, -16'sd1, Z}};
        tv[2] = '{'{16'sd32000, -16'sd32000, 16'sd5, -16'sd32768}, '{U, U, U, -16'sd16384},
                  '{16'sd1000, -16'sd1000, Z, Z}, '{16'sd32767, -16'sd32768, 16'sd5, 16'sd32767}};
        tv[3] = '{'{16'sd1001, 16'sd1000, -16'sd3, 16'sd12345}, '{-16'sd8192, 16'sd24576, U, Z},
                  '{Z, Z, -16'sd5, 16'sd7}, '{-16'sd501, 16'sd1500, -16'sd8, 16'sd7}};
        si = zeros;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out0", int'(so[0]), 0);
        chk("reset out3", int'(so[3]), 0);
        chk("reset flags", int'({out_valid, busy, overrun}), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int v = 0; v < 4; v++) begin
            if (v > 0) load(tv[v].g, tv[v].o);
            run_frame($sformatf("vec%0d", v), tv[v].in, tv[v].e, -1, -1, 3'd0, Z);
        end
        chk("no_overrun_yet", int'(overrun), 0);
        run_frame("reedge_E4", tv[3].in, tv[3].e, 4, -1, 3'd0, Z);
        chk("overrun_set", int'(overrun), 1);
        run_frame("after_overrun", tv[3].in, tv[3].e, -1, -1, 3'd0, Z);
        chk("overrun_sticky", int'(overrun), 1);
        load(ones, zeros);
        run_frame("wr_busy_old", '{16'sd4000, Z, Z, Z}, '{16'sd4000, Z, Z, Z}, -1, 3, 3'd0, 16'sd8192);
        run_frame("wr_busy_new", '{16'sd4000, Z, Z, Z}, '{16'sd2000, Z, Z, Z}, -1, -1, 3'd0, Z);
        run_frame("wr_E0_old", '{16'sd4000, Z, Z, Z}, '{16'sd2000, Z, Z, Z}, -1, 0, 3'd0, U);
        run_frame("wr_E0_new", '{16'sd4000, Z, Z, Z}, '{16'sd4000, Z, Z, Z}, -1, -1, 3'd0, Z);
        jack = 8'h30;
`ifdef CAL_MUTE_UNPATCHED_EN
        e_mute = '{16'sd100, 16'sd200, Z, Z};
`else
        e_mute = '{16'sd100, 16'sd200, 16'sd300, 16'sd400};
`endif
        run_frame("jack30", '{16'sd100, 16'sd200, 16'sd300, 16'sd400}, e_mute, -1, -1, 3'd0, Z);
        jack = 8'hF0;
        load('{16'sd8192, U, U, U}, zeros);
        @(negedge clk);
        si = '{16'sd4000, 16'sd8, 16'sd8, 16'sd8};
        sample_clk = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_clk = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst out0", int'(so[0]), 0);
        chk("midrst out1", int'(so[1]), 0);
        chk("midrst flags", int'({out_valid, busy, overrun}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        begin
            int vc = 0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk);
                #1 if (out_valid) vc++;
            end
            chk("abandoned_frame_pulses", vc, 0);
        end
        run_frame("post_reset", '{16'sd4000, Z, Z, -16'sd4000}, '{16'sd4000, Z, Z, -16'sd4000}, 9, -1, 3'd0, Z);
        chk("start_at_commit_overrun", int'(overrun), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
